alarm_clock: RTL and testbench



---
 rtl/alarm_pkg.sv | 38 +++
 rtl/tone_div.sv | 50 +++++
 rtl/alarm_clock.sv | 106 ++++++++++
 tb/tb_alarm_clock.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared constants and helpers for the alarm tone/cadence generator.
//   - Cadence mode encodings (count_light1): CAD_CONT, CAD_SLOW, CAD_FAST,
//     CAD_DOUBLE.
//   - Tone selector encodings (count_light): TONE_OFF, TONE_LOW, TONE_MID,
//     TONE_HIGH.
//   - cadence_pattern(): maps a cadence mode and the 3-bit phase to the
//     on/off beep pattern bit.
// -----------------------------------------------------------------------------
package alarm_pkg;

  localparam logic [1:0] CAD_CONT   = 2'd0;
  localparam logic [1:0] CAD_SLOW   = 2'd1;
  localparam logic [1:0] CAD_FAST   = 2'd2;
  localparam logic [1:0] CAD_DOUBLE = 2'd3;

  localparam logic [1:0] TONE_OFF  = 2'd0;
  localparam logic [1:0] TONE_LOW  = 2'd1;
  localparam logic [1:0] TONE_MID  = 2'd2;
  localparam logic [1:0] TONE_HIGH = 2'd3;

  // Every mode is "on" at phase 0, so a restarted pattern always begins
  // with a beep.
  function automatic logic cadence_pattern(input logic [1:0] mode,
                                           input logic [2:0] phase);
    logic on;
    case (mode)
      CAD_CONT: on = 1'b1;
      CAD_SLOW: on = ~phase[2];                          // 4 on, 4 off
      CAD_FAST: on = ~phase[0];                          // 1 on, 1 off
      CAD_DOUBLE: on = (phase == 3'd0) || (phase == 3'd2); // beep, gap, beep
      default: on = 1'b1;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/tone_div.sv
// -----------------------------------------------------------------------------
// tone_div
// Square-wave tone divider. While en is high the counter runs 0..half-1 and
// the output toggles each time it wraps, giving a period of 2*half cycles.
// While en is low the counter is cleared and the output is held low, so every
// beep starts with a full low half-period.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   en      : tone gate
//   restart : clear the counter (pitch changed); output level is kept
//   half    : half-period in clk cycles
//   wave    : square-wave output
// -----------------------------------------------------------------------------
module tone_div #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         restart,
  input  logic [W-1:0] half,
  output logic         wave
);

  logic [W-1:0] cnt;
  logic [W-1:0] base;
  logic [W-1:0] last;

  // A restart edge counts as count 0, so the first toggle after the gate
  // opens still lands exactly half edges later.
  assign base = restart ? '0 : cnt;
  assign last = half - W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (base == last) begin
      cnt  <= '0;
      wave <= ~wave;
    end else begin
      cnt  <= base + W'(1);
    end
  end

endmodule

// File: rtl/alarm_clock.sv
// -----------------------------------------------------------------------------
// alarm_clock
// Alarm tone and cadence generator. Registers the two selectors, runs a tick
// counter and 3-bit phase counter for the beep cadence, forms the tone gate
// and drives a tone_div instance for the buzzer square wave.
// Ports:
//   I_CLK        : system clock, rising edge
//   Rst          : asynchronous active-low reset
//   count_light  : 0 = alarm off, 1/2/3 = tone LOW/MID/HIGH
//   count_light1 : cadence (0 continuous, 1 slow, 2 fast, 3 double-beep)
//   O_CLK        : buzzer square wave, 0 when silent
//   num          : registered gate, 1 while the tone is audible
// -----------------------------------------------------------------------------
module alarm_clock
  import alarm_pkg::*;
#(
  parameter int DIV_LOW  = 50000,
  parameter int DIV_MID  = 37500,
  parameter int DIV_HIGH = 25000,
  parameter int TICK     = 12500000
) (
  input  logic       I_CLK,
  input  logic       Rst,
  input  logic [1:0] count_light,
  input  logic [1:0] count_light1,
  output logic       O_CLK,
  output logic       num
);

  localparam int DIV_MAX = (DIV_LOW > DIV_MID) ?
                           ((DIV_LOW > DIV_HIGH) ? DIV_LOW : DIV_HIGH) :
                           ((DIV_MID > DIV_HIGH) ? DIV_MID : DIV_HIGH);
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int TICK_W  = (TICK > 1) ? $clog2(TICK) : 1;

  logic [1:0]        cl_q;
  logic [1:0]        cl1_q;
  logic [1:0]        cl_prev;
  logic [1:0]        cl1_prev;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        phase;
  logic              tick;
  logic              cad_change;
  logic              pitch_change;
  logic              gate;
  logic [DIV_W-1:0]  half;

  assign tick         = (tick_cnt == TICK_W'(TICK - 1));
  assign cad_change   = (cl1_q != cl1_prev);
  assign pitch_change = (cl_q != cl_prev);
  assign gate         = (cl_q != TONE_OFF) && cadence_pattern(cl1_q, phase);

  always_comb begin
    half = DIV_W'(DIV_LOW);
    case (cl_q)
      TONE_LOW:  half = DIV_W'(DIV_LOW);
      TONE_MID:  half = DIV_W'(DIV_MID);
      TONE_HIGH: half = DIV_W'(DIV_HIGH);
      TONE_OFF:  half = DIV_W'(DIV_LOW);   // don't care, divider is gated off
      default:   half = DIV_W'(DIV_LOW);
    endcase
  end

  // Input registers, cadence counters and registered gate.
  always_ff @(posedge I_CLK or negedge Rst) begin
    if (!Rst) begin
      cl_q     <= 2'd0;
      cl1_q    <= 2'd0;
      cl_prev  <= 2'd0;
      cl1_prev <= 2'd0;
      tick_cnt <= '0;
      phase    <= 3'd0;
      num      <= 1'b0;
    end else begin
      cl_q     <= count_light;
      cl1_q    <= count_light1;
      cl_prev  <= cl_q;
      cl1_prev <= cl1_q;
      num      <= gate;
      // A cadence change restarts the pattern at phase 0 with a fresh tick.
      if (cad_change) begin
        tick_cnt <= '0;
        phase    <= 3'd0;
      end else if (tick) begin
        tick_cnt <= '0;
        phase    <= phase + 3'd1;
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  // Tone divider: gate and half-period are sampled on the same edge as num,
  // so O_CLK starts and stops in step with num.
  tone_div #(
    .W(DIV_W)
  ) u_tone_div (
    .clk    (I_CLK),
    .rst_n  (Rst),
    .en     (gate),
    .restart(pitch_change),
    .half   (half),
    .wave   (O_CLK)
  );

endmodule

// File: tb/tb_alarm_clock.sv
module tb_alarm_clock;

  logic       I_CLK = 1'b0;
  logic       Rst = 1'b0;
  logic [1:0] count_light = 2'd0;
  logic [1:0] count_light1 = 2'd0;
  logic       O_CLK;
  logic       num;

  bit clk_run = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  bit exp_num_q[$];
  bit exp_o_q[$];
  bit en_a[0:255];
  bit o_a[0:255];

  alarm_clock #(
    .DIV_LOW (4),
    .DIV_MID (3),
    .DIV_HIGH(2),
    .TICK    (8)
  ) dut (
    .I_CLK       (I_CLK),
    .Rst         (Rst),
    .count_light (count_light),
    .count_light1(count_light1),
    .O_CLK       (O_CLK),
    .num         (num)
  );

  always #5 if (clk_run) I_CLK = ~I_CLK;

  // Expected pattern bit of each cadence mode for a phase 0..7.
  function automatic bit pat(int mode, int ph);
    case (mode)
      0: return 1'b1;
      1: return ph < 4;
      2: return (ph % 2) == 0;
      default: return (ph == 0) || (ph == 2);
    endcase
  endfunction

  // Expected O_CLK from the expected num sequence: within a beep, edge j
  // (j=0 is the first edge with the gate open) the wave is high for
  // j in [div-1, 2div-2], low for the next div edges, and so on.
  task automatic model_o(input int n, input int div);
    int j;
    bit prev;
    j = 0;
    prev = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (en_a[k]) begin
        j = prev ? j + 1 : 0;
        o_a[k] = ((j + div + 1) % (2 * div)) < div;
      end else begin
        o_a[k] = 1'b0;
      end
      prev = en_a[k];
    end
  endtask

  task automatic push_all(input int n);
    exp_num_q.delete();
    exp_o_q.delete();
    for (int k = 1; k <= n; k++) begin
      exp_num_q.push_back(en_a[k]);
      exp_o_q.push_back(o_a[k]);
    end
  endtask

  task automatic do_reset();
    clk_run = 1'b1;
    Rst = 1'b0;
    count_light = 2'd0;
    count_light1 = 2'd0;
    repeat (3) @(negedge I_CLK);
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    clk_run = 1'b1;
    Rst = 1'b0;
    count_light = 2'd3;
    count_light1 = 2'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge I_CLK);
      vectors++;
      if (num !== 1'b0 || O_CLK !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_held k=%0d num=%b O_CLK=%b expected 0 0", k, num, O_CLK);
      end
    end
    count_light = 2'd1;
    count_light1 = 2'd0;
    Rst = 1'b1;
    repeat (6) @(negedge I_CLK);
    vectors++;
    if (num !== 1'b1 || O_CLK !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_prebeep num=%b O_CLK=%b expected 1 1", num, O_CLK);
    end
    clk_run = 1'b0;
    #2;
    Rst = 1'b0;
    #1;
    vectors++;
    if (num !== 1'b0 || O_CLK !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async num=%b O_CLK=%b expected 0 0", num, O_CLK);
    end
    #30;
    vectors++;
    if (num !== 1'b0 || O_CLK !== 1'b0 || I_CLK !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_noclk num=%b O_CLK=%b clk=%b expected 0 0 0", num, O_CLK, I_CLK);
    end
    clk_run = 1'b1;
  endtask

  task automatic test_off();
    bit en, o;
    do_reset();
    exp_num_q.delete();
    exp_o_q.delete();
    for (int k = 1; k <= 200; k++) begin
      count_light = 2'd0;
      count_light1 = 2'((k / 50) % 4);
      exp_num_q.push_back(1'b0);
      exp_o_q.push_back(1'b0);
      @(negedge I_CLK);
      en = exp_num_q.pop_front();
      o = exp_o_q.pop_front();
      vectors++;
      if (num !== en || O_CLK !== o) begin
        miscompares++;
        $display("FAIL off k=%0d num=%b O_CLK=%b expected %b %b", k, num, O_CLK, en, o);
      end
    end
  endtask

  task automatic test_continuous_low();
    bit en, o;
    do_reset();
    count_light = 2'd1;
    count_light1 = 2'd0;
    en_a[1] = 1'b0;
    for (int k = 2; k <= 40; k++) en_a[k] = 1'b1;
    model_o(40, 4);
    push_all(40);
    for (int k = 1; k <= 40; k++) begin
      @(negedge I_CLK);
      en = exp_num_q.pop_front();
      o = exp_o_q.pop_front();
      vectors++;
      if (num !== en || O_CLK !== o) begin
        miscompares++;
        $display("FAIL cont_low k=%0d num=%b O_CLK=%b expected %b %b", k, num, O_CLK, en, o);
      end
    end
  endtask

  task automatic test_slow_high();
    bit en, o;
    do_reset();
    count_light = 2'd3;
    count_light1 = 2'd1;
    en_a[1] = 1'b0;
    en_a[2] = 1'b1;
    for (int k = 3; k <= 140; k++) en_a[k] = pat(1, ((k - 3) / 8) % 8);
    model_o(140, 2);
    push_all(140);
    for (int k = 1; k <= 140; k++) begin
      @(negedge I_CLK);
      en = exp_num_q.pop_front();
      o = exp_o_q.pop_front();
      vectors++;
      if (num !== en || O_CLK !== o) begin
        miscompares++;
        $display("FAIL slow_high k=%0d num=%b O_CLK=%b expected %b %b", k, num, O_CLK, en, o);
      end
    end
  endtask

  task automatic test_double_beep();
    bit en, o;
    do_reset();
    count_light = 2'd2;
    count_light1 = 2'd3;
    en_a[1] = 1'b0;
    en_a[2] = 1'b1;
    for (int k = 3; k <= 23; k++) en_a[k] = pat(3, ((k - 3) / 8) % 8);
    en_a[24] = 1'b1;
    for (int k = 25; k <= 70; k++) en_a[k] = pat(2, ((k - 25) / 8) % 8);
    model_o(70, 3);
    push_all(70);
    for (int k = 1; k <= 70; k++) begin
      @(negedge I_CLK);
      en = exp_num_q.pop_front();
      o = exp_o_q.pop_front();
      vectors++;
      if (num !== en || O_CLK !== o) begin
        miscompares++;
        $display("FAIL double_beep k=%0d num=%b O_CLK=%b expected %b %b", k, num, O_CLK, en, o);
      end
      if (k == 22) count_light1 = 2'd2;
    end
  endtask

  task automatic test_pitch_change();
    bit en, o;
    localparam int C = 14;
    do_reset();
    count_light = 2'd1;
    count_light1 = 2'd0;
    en_a[1] = 1'b0;
    for (int k = 2; k <= 36; k++) en_a[k] = 1'b1;
    model_o(C, 4);
    o_a[C + 1] = o_a[C];
    for (int k = C + 2; k <= 36; k++)
      o_a[k] = (((k - C - 2) / 2) % 2 == 0) ? ~o_a[C] : o_a[C];
    push_all(36);
    for (int k = 1; k <= 36; k++) begin
      @(negedge I_CLK);
      en = exp_num_q.pop_front();
      o = exp_o_q.pop_front();
      vectors++;
      if (num !== en || O_CLK !== o) begin
        miscompares++;
        $display("FAIL pitch_change k=%0d num=%b O_CLK=%b expected %b %b", k, num, O_CLK, en, o);
      end
      if (k == C - 1) count_light = 2'd3;
    end
  endtask

  initial begin
    test_reset();
    test_off();
    test_continuous_low();
    test_slow_high();
    test_double_beep();
    test_pitch_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
